// File: rtl/visaccum.sv
// Visibility accumulator: per-component SRAM accumulation across frames, results streamed
// through a registered-output FIFO. Define VISACCUM_SATURATE_EN for a clamping adder.
module visaccum #(
  parameter int IBITS  = 7,
  parameter int OBITS  = 36,
  parameter int NSUMS  = 1024,
  parameter int SIGNED = 1,
  parameter int ODEPTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [IBITS-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             first_o,
  output logic             last_o,
  output logic [OBITS-1:0] data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(NSUMS);
  localparam int PW = $clog2(ODEPTH);
  localparam int EW = OBITS + 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NSUMS - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(ODEPTH);

  logic [AW-1:0]    addr_q, addr_d;
  logic             s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [AW-1:0]    s1_addr_q, s1_addr_d;
  logic [IBITS-1:0] s1_data_q, s1_data_d;
  logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [AW-1:0]    s2_addr_q, s2_addr_d;
  logic [IBITS-1:0] s2_data_q, s2_data_d;
  logic [OBITS-1:0] rd_q, rd_d;
  logic             s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic [AW-1:0]    s3_addr_q, s3_addr_d;
  logic [OBITS-1:0] sum_q, sum_d;
  logic [OBITS-1:0] ext_data;

  logic [OBITS-1:0] acc_mem [NSUMS];

  logic [EW-1:0]    fifo_mem [ODEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic [EW-1:0]    out_word_q, out_word_d, push_word;
  logic             push_req, push, pop, full;

  // Input capture, SRAM read, add; the adder result is written back one edge later.
  always_comb begin
    addr_d     = addr_q;
    if (valid_i) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
    s1_valid_d = valid_i;
    s1_first_d = first_i;
    s1_last_d  = last_i;
    s1_addr_d  = addr_q;
    s1_data_d  = data_i;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = s1_data_q;
    rd_d       = s1_first_q ? '0 : acc_mem[s1_addr_q];
    s3_valid_d = s2_valid_q;
    s3_last_d  = s2_last_q;
    s3_addr_d  = s2_addr_q;
    ext_data   = (SIGNED != 0) ? {{(OBITS-IBITS){s2_data_q[IBITS-1]}}, s2_data_q}
                               : {{(OBITS-IBITS){1'b0}}, s2_data_q};
    sum_d      = rd_q + ext_data;
  end

`ifdef VISACCUM_SATURATE_EN
  logic [OBITS:0] sum_wide;
  logic [OBITS-1:0] sum_sat;
  always_comb begin
    sum_wide = {1'b0, rd_q} + {1'b0, ext_data};
    sum_sat  = sum_wide[OBITS-1:0];
    if (SIGNED != 0) begin
      // Signed overflow: operands agree in sign but the result does not.
      if ((rd_q[OBITS-1] == ext_data[OBITS-1]) && (sum_sat[OBITS-1] != rd_q[OBITS-1]))
        sum_sat = rd_q[OBITS-1] ? {1'b1, {(OBITS-1){1'b0}}} : {1'b0, {(OBITS-1){1'b1}}};
    end else if (sum_wide[OBITS]) begin
      sum_sat = '1;
    end
  end
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      rd_q       <= '0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_addr_q  <= '0;
      sum_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
      rd_q       <= rd_d;
      s3_valid_q <= s3_valid_d;
      s3_last_q  <= s3_last_d;
      s3_addr_q  <= s3_addr_d;
`ifdef VISACCUM_SATURATE_EN
      sum_q      <= sum_sat;
`else
      sum_q      <= sum_d;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (s3_valid_q) acc_mem[s3_addr_q] <= sum_q;
  end

  // Handshake: a beat moves when valid_o & ready_i at a rising edge; while valid_o is high
  // and ready_i low, data_o/first_o/last_o hold. The upstream side has no backpressure.
  always_comb begin
    push_req  = s3_valid_q & s3_last_q;
    push_word = {sum_q, (s3_addr_q == '0), (s3_addr_q == LAST_ADDR)};
    pop       = out_valid_q & ready_i;
    full      = (count_q == FULL_CNT);
    push      = push_req & (~full | pop);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + (PW+1)'(push) - (PW+1)'(pop);
    overflow_d  = overflow_q | (push_req & full & ~pop);
    out_valid_d = (count_d != '0);
    out_word_d  = out_word_q;
    // The output register mirrors the head entry; a push into an emptied FIFO bypasses the array.
    if (count_d != '0)
      out_word_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_word : fifo_mem[rd_ptr_d];
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

  assign valid_o    = out_valid_q;
  assign data_o     = out_word_q[EW-1:2];
  assign first_o    = out_word_q[1];
  assign last_o     = out_word_q[0];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_visaccum.sv
// Bench for visaccum: behavioural accumulator model feeds an expected queue that is
// compared against every output transfer.
module tb_visaccum;

  localparam int IBITS  = 7;
  localparam int OBITS  = 12;
  localparam int NSUMS  = 8;
  localparam int SIGNED = 1;
  localparam int ODEPTH = 4;
  localparam longint MASK = (64'd1 << OBITS) - 1;

  logic             clock_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             first_i = 1'b0;
  logic             last_i  = 1'b0;
  logic [IBITS-1:0] data_i  = '0;
  logic             ready_i = 1'b1;
  logic             valid_o, first_o, last_o, overflow_o;
  logic [OBITS-1:0] data_o;

  visaccum #(.IBITS(IBITS), .OBITS(OBITS), .NSUMS(NSUMS), .SIGNED(SIGNED), .ODEPTH(ODEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .first_i(first_i),
    .last_i(last_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .first_o(first_o), .last_o(last_o), .data_o(data_o), .overflow_o(overflow_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;
  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;
  logic [OBITS+1:0] exp_q[$];
  longint acc_m [NSUMS];
  int comp_m = 0;
  int last_acc = 0;
  int lat_cyc = 0;
  bit lat_arm = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint model_add(input longint a, input longint v);
    longint s;
    s = a + v;
`ifdef VISACCUM_SATURATE_EN
    if (SIGNED != 0) begin
      if (s > (64'sd1 <<< (OBITS-1)) - 1) s = (64'sd1 <<< (OBITS-1)) - 1;
      if (s < -(64'sd1 <<< (OBITS-1)))    s = -(64'sd1 <<< (OBITS-1));
    end else if (s > MASK) begin
      s = MASK;
    end
`else
    s = s & MASK;
`endif
    return s;
  endfunction

  // driver tasks
  task automatic drive_beat(input logic [IBITS-1:0] d, input bit f, input bit l, input bit keep);
    longint v;
    @(negedge clock_i);
    valid_i = 1'b1; first_i = f; last_i = l; data_i = d;
    last_acc = cyc + 1;
    v = (SIGNED != 0) ? longint'($signed(d)) : longint'({1'b0, d});
    acc_m[comp_m] = model_add(f ? 64'sd0 : acc_m[comp_m], v);
    if (l && keep)
      exp_q.push_back({OBITS'(acc_m[comp_m]), comp_m == 0, comp_m == NSUMS - 1});
    comp_m = (comp_m == NSUMS - 1) ? 0 : comp_m + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock_i);
      valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    exp_q.delete();
    comp_m = 0;
    lat_arm = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clock_i);
      k++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_valid"}, valid_o, 0);
    check({pfx, "_first"}, first_o, 0);
    check({pfx, "_last"}, last_o, 0);
    check({pfx, "_data"}, data_o, 0);
    check({pfx, "_ovf"}, overflow_o, 0);
  endtask

  // scoreboard: compare on every transfer, check head stability while stalled
  always @(negedge clock_i) begin
    #2;
    if (!reset_i) begin
      if (lat_arm && valid_o) begin
        check("latency", cyc - lat_cyc, 3);
        lat_arm = 1'b0;
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("unexpected_out", exp_q.size(), 1);
        else check("out", {data_o, first_o, last_o}, exp_q.pop_front());
      end else if (valid_o && exp_q.size() > 0) begin
        check("hold", {data_o, first_o, last_o}, exp_q[0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on reset
    repeat (2) @(negedge clock_i);
    #1 check_zero_outputs("por");
    @(negedge clock_i);
    reset_i = 1'b0;

    // basic accumulation, with latency from the last frame's first beat
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < NSUMS; c++) begin
        drive_beat(IBITS'(c + 1), f == 0, f == 2, 1'b1);
        if (f == 2 && c == 0) begin
          lat_cyc = last_acc;
          lat_arm = 1'b1;
        end
      end
    idle(1);
    wait_drain(40);
    check("latency_seen", lat_arm, 0);

    // same frames with random idle gaps
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < NSUMS; c++) begin
        drive_beat(IBITS'(c + 1), f == 0, f == 2, 1'b1);
        idle($urandom_range(0, 5));
      end
    idle(1);
    wait_drain(40);

    // signed: four frames of -1
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < NSUMS; c++)
        drive_beat(7'h7F, f == 0, f == 3, 1'b1);
    idle(1);
    wait_drain(40);

    // backpressure: only ODEPTH beats fit, the rest are dropped
    check("ovf_pre", overflow_o, 0);
    ready_i = 1'b0;
    for (int c = 0; c < NSUMS; c++)
      drive_beat(IBITS'($urandom_range(0, 127)), 1'b1, 1'b1, c < ODEPTH);
    idle(6);
    check("ovf_set", overflow_o, 1);
    check("stall_valid", valid_o, 1);
    idle(3);
    ready_i = 1'b1;
    wait_drain(20);
    check("ovf_sticky", overflow_o, 1);

    // reset mid-frame while stalled with valid_i high
    ready_i = 1'b0;
    for (int c = 0; c < 3; c++)
      drive_beat(IBITS'($urandom_range(0, 127)), 1'b1, 1'b1, 1'b1);
    idle(5);
    check("pre_rst_valid", valid_o, 1);
    @(negedge clock_i);
    valid_i = 1'b1; first_i = 1'b1; last_i = 1'b1; data_i = 7'd5;
    @(posedge clock_i);
    #2 reset_i = 1'b1;
    #1 check_zero_outputs("mid_rst");
    do_reset();
    ready_i = 1'b1;
    for (int c = 0; c < NSUMS; c++)
      drive_beat(IBITS'($urandom_range(0, 127)), 1'b1, 1'b1, 1'b1);
    idle(1);
    wait_drain(40);

    // long accumulation past the OBITS range
    do_reset();
    check("ovf_clear", overflow_o, 0);
    for (int f = 0; f < 100; f++)
      for (int c = 0; c < NSUMS; c++)
        drive_beat(7'd63, f == 0, f == 99, 1'b1);
    idle(1);
    wait_drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
